color_bbox_extractor: RTL
=========================

// Module: color_bbox_extractor
// PURPOSE
//  Streaming pixel-to-geometry extractor: the inverse of the sprite renderers. Watches the
//  (hcount, vcount, rgb) pixel stream and finds every pixel within TOL of COLOR. At end of frame
//  it publishes the bounding box and hit count. Output coords feed minmax_block_sprite directly.
// PARAMETERS
//  COLOR     24'hFF_00_00  target color {R,G,B}
//  TOL       8'd16         max per-channel |pixel - target| counted as a hit (inclusive)
//  H_ACTIVE  1280          active pixels per line; hcount >= H_ACTIVE ignored
//  V_ACTIVE  720           active lines per frame; vcount >= V_ACTIVE ignored
//  CNT_W     20            pixel counter width
// PORTS
//  clk_in           in   1      pixel clock
//  rst_in           in   1      synchronous active-high reset
//  hcount_in        in   11     pixel x
//  vcount_in        in   10     pixel y
//  data_valid_in    in   1      pixel qualifier; all other inputs ignored when 0
//  red_in/green_in/blue_in in 8 each   pixel color
//  xmin_out         out  12     bbox left (inclusive)
//  ymin_out         out  11     bbox top (inclusive)
//  xmax_out         out  12     bbox right (inclusive)
//  ymax_out         out  11     bbox bottom (inclusive)
//  count_out        out  CNT_W  hit pixels in frame, saturating at 2^CNT_W-1
//  found_out        out  1      1 if count_out > 0
//  valid_out        out  1      1-cycle pulse: all outputs updated this cycle
// BEHAVIOUR
//  - Accepted pixel: data_valid_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE.
//    SOF = accepted at (0,0). EOF = accepted at (H_ACTIVE-1, V_ACTIVE-1).
//  - Stage 1 (registered): hit = accepted && |R-CR|<=TOL && |G-CG|<=TOL && |B-CB|<=TOL.
//    Use 9-bit unsigned differences, no wrap. Register h, v, sof, eof alongside hit.
//  - Stage 2: FSM {IDLE, ACCUM}. IDLE ignores everything except stage-1 SOF.
//  - SOF (any state): accumulators re-init from this pixel only; enter ACCUM.
//    Init: hit -> min=max=(h,v), cnt=1; no hit -> xmin=ymin=all-ones, xmax=ymax=0, cnt=0.
//    SOF arriving mid-ACCUM discards the partial frame; nothing is published.
//  - ACCUM, non-SOF hit: xmin=min(xmin,h), xmax=max(xmax,h), same for y; cnt+=1, saturating.
//  - ACCUM, EOF: merge the EOF pixel. Load outputs with the merged values. valid_out=1 on the
//    next edge, 2 cycles after EOF is presented at the inputs. Return to IDLE.
//  - Empty frame (merged cnt=0): found_out=0, all coord outputs 0, count_out=0; valid_out still pulses.
//  - EOF seen while in IDLE: ignored, no pulse.
//  - Outputs hold between pulses. valid_out is low except for the 1-cycle publish pulse.
//  - Reset: outputs, FSM and accumulators clear. All outputs 0, state IDLE.
//    A frame in progress at reset is never published. The first publish after reset needs a full SOF..EOF.
//  - data_valid_in=0 cycles (blanking, stalls) do not affect state. Hits may be non-contiguous.
// TESTING  (H_ACTIVE=8, V_ACTIVE=6, COLOR=FF0000, TOL=16 unless noted)
//  1. Frame with hits at (2,1),(5,1),(3,4), rest black -> one valid pulse, 2 cycles after EOF.
//     Expect bbox (2,1)-(5,4), count=3, found=1.
//  2. All-black frame -> valid pulse with found=0, coords 0, count 0.
//     Then pixel EF1010 at (0,0) -> hit. Pixel EE0000 (diff 17) -> no hit.
//  3. Hits only at (0,0) and (7,5), with data_valid gaps between pixels -> bbox (0,0)-(7,5), count=2.
//  4. SOF, hits at (1,1), then second SOF at cycle 20 with a hit at (6,3) before EOF
//     -> single pulse: bbox (6,3)-(6,3), count=1.
//  5. rst_in pulsed mid-frame -> outputs 0 next cycle; the following EOF gives no pulse.
//     The next full frame publishes correctly.
//  6. CNT_W=3, frame with 10 hits -> count_out=7 (saturated), found=1.

Source files
------------

// File: rtl/color_bbox_extractor_if.sv
// Pixel stream in, per-frame bounding-box result out, for color_bbox_extractor.
// The master drives pixels; the slave is the extractor.
interface color_bbox_extractor_if #(
    parameter int CNT_W = 20
);
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             data_valid_in;
    logic [7:0]       red_in;
    logic [7:0]       green_in;
    logic [7:0]       blue_in;
    logic [11:0]      xmin_out;
    logic [10:0]      ymin_out;
    logic [11:0]      xmax_out;
    logic [10:0]      ymax_out;
    logic [CNT_W-1:0] count_out;
    logic             found_out;
    logic             valid_out;

    modport master (
        output hcount_in, vcount_in, data_valid_in, red_in, green_in, blue_in,
        input  xmin_out, ymin_out, xmax_out, ymax_out, count_out, found_out, valid_out
    );

    modport slave (
        input  hcount_in, vcount_in, data_valid_in, red_in, green_in, blue_in,
        output xmin_out, ymin_out, xmax_out, ymax_out, count_out, found_out, valid_out
    );
endinterface

// File: rtl/color_bbox_extractor.sv
// Finds pixels within TOL of COLOR in a raster stream and publishes their bounding
// box and hit count once per complete SOF..EOF frame.
module color_bbox_extractor #(
    parameter logic [23:0] COLOR    = 24'hFF_00_00,
    parameter logic [7:0]  TOL      = 8'd16,
    parameter int          H_ACTIVE = 1280,
    parameter int          V_ACTIVE = 720,
    parameter int          CNT_W    = 20
) (
    input logic                   clk_in,
    input logic                   rst_in,
    color_bbox_extractor_if.slave px
);
    // state | meaning
    // IDLE  | waiting for a start-of-frame pixel; everything else ignored
    // ACCUM | inside a frame, merging hits into the accumulators
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    localparam logic [31:0] H_LIM = 32'(H_ACTIVE);
    localparam logic [31:0] V_LIM = 32'(V_ACTIVE);

    // 9-bit magnitude so a difference of 255 never wraps into the tolerance window
    function automatic logic near(input logic [7:0] p, input logic [7:0] c);
        logic [8:0] d;
        d = (p >= c) ? ({1'b0, p} - {1'b0, c}) : ({1'b0, c} - {1'b0, p});
        return d <= {1'b0, TOL};
    endfunction

    logic        accept;
    logic        hit_d, sof_d, eof_d;
    logic        hit_q, sof_q, eof_q;
    logic [10:0] h_q;
    logic [9:0]  v_q;

    always_comb begin
        accept = px.data_valid_in && (32'(px.hcount_in) < H_LIM) && (32'(px.vcount_in) < V_LIM);
        hit_d  = accept && near(px.red_in, COLOR[23:16]) && near(px.green_in, COLOR[15:8])
                 && near(px.blue_in, COLOR[7:0]);
        sof_d  = accept && (px.hcount_in == 11'd0) && (px.vcount_in == 10'd0);
        eof_d  = accept && (32'(px.hcount_in) == H_LIM - 32'd1)
                 && (32'(px.vcount_in) == V_LIM - 32'd1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_q <= 1'b0;
            sof_q <= 1'b0;
            eof_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            hit_q <= hit_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            h_q   <= px.hcount_in;
            v_q   <= px.vcount_in;
        end
    end

    state_t           state_q, state_d;
    logic [11:0]      xmin_q, xmin_d, xmax_q, xmax_d;
    logic [10:0]      ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      m_xmin, m_xmax;
    logic [10:0]      m_ymin, m_ymax;
    logic [CNT_W-1:0] m_cnt;
    logic [11:0]      o_xmin_q, o_xmin_d, o_xmax_q, o_xmax_d;
    logic [10:0]      o_ymin_q, o_ymin_d, o_ymax_q, o_ymax_d;
    logic [CNT_W-1:0] o_cnt_q, o_cnt_d;
    logic             o_found_q, o_found_d;
    logic             o_valid_q, o_valid_d;
    logic             publish;
    logic [11:0]      h_ext;
    logic [10:0]      v_ext;

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    // Accumulators after merging the current stage-1 pixel; SOF restarts from this pixel alone
    always_comb begin
        m_xmin = xmin_q;
        m_xmax = xmax_q;
        m_ymin = ymin_q;
        m_ymax = ymax_q;
        m_cnt  = cnt_q;
        if (sof_q) begin
            if (hit_q) begin
                m_xmin = h_ext;
                m_xmax = h_ext;
                m_ymin = v_ext;
                m_ymax = v_ext;
                m_cnt  = CNT_W'(1);
            end else begin
                m_xmin = '1;
                m_ymin = '1;
                m_xmax = '0;
                m_ymax = '0;
                m_cnt  = '0;
            end
        end else if (hit_q) begin
            if (h_ext < xmin_q) m_xmin = h_ext;
            if (h_ext > xmax_q) m_xmax = h_ext;
            if (v_ext < ymin_q) m_ymin = v_ext;
            if (v_ext > ymax_q) m_ymax = v_ext;
            if (cnt_q != '1)    m_cnt  = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        cnt_d     = cnt_q;
        o_xmin_d  = o_xmin_q;
        o_xmax_d  = o_xmax_q;
        o_ymin_d  = o_ymin_q;
        o_ymax_d  = o_ymax_q;
        o_cnt_d   = o_cnt_q;
        o_found_d = o_found_q;
        o_valid_d = 1'b0;
        publish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof_q) begin
                    {xmin_d, xmax_d, ymin_d, ymax_d, cnt_d} = {m_xmin, m_xmax, m_ymin, m_ymax, m_cnt};
                    if (eof_q) publish = 1'b1;
                    else       state_d = ACCUM;
                end
            end
            ACCUM: begin
                {xmin_d, xmax_d, ymin_d, ymax_d, cnt_d} = {m_xmin, m_xmax, m_ymin, m_ymax, m_cnt};
                if (eof_q) begin
                    publish = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (publish) begin
            o_valid_d = 1'b1;
            o_found_d = (m_cnt != '0);
            o_cnt_d   = m_cnt;
            o_xmin_d  = o_found_d ? m_xmin : '0;
            o_xmax_d  = o_found_d ? m_xmax : '0;
            o_ymin_d  = o_found_d ? m_ymin : '0;
            o_ymax_d  = o_found_d ? m_ymax : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            cnt_q     <= '0;
            o_xmin_q  <= '0;
            o_xmax_q  <= '0;
            o_ymin_q  <= '0;
            o_ymax_q  <= '0;
            o_cnt_q   <= '0;
            o_found_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cnt_q     <= cnt_d;
            o_xmin_q  <= o_xmin_d;
            o_xmax_q  <= o_xmax_d;
            o_ymin_q  <= o_ymin_d;
            o_ymax_q  <= o_ymax_d;
            o_cnt_q   <= o_cnt_d;
            o_found_q <= o_found_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign px.xmin_out  = o_xmin_q;
    assign px.xmax_out  = o_xmax_q;
    assign px.ymin_out  = o_ymin_q;
    assign px.ymax_out  = o_ymax_q;
    assign px.count_out = o_cnt_q;
    assign px.found_out = o_found_q;
    assign px.valid_out = o_valid_q;
endmodule
